// File: rtl/bounce_engine.sv
// bounce_engine: sequences erase/draw requests to the box drawer on each
// frame tick, advancing and reflecting the box position between them.
module bounce_engine #(
    parameter int unsigned X_INIT = 81,
    parameter int unsigned Y_INIT = 0,
    parameter int unsigned X_MAX  = 156,
    parameter int unsigned Y_MAX  = 116,
    parameter int unsigned STEP   = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       go,
    input  logic       tick,
    input  logic       done,
    output logic       req,
    output logic       erase,
    output logic [7:0] box_x,
    output logic [6:0] box_y,
    output logic       dir_x,
    output logic       dir_y,
    output logic [7:0] bounce_cnt,
    output logic       overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAW,
        S_WAIT,
        S_ERASE,
        S_MOVE
    } state_t;

    localparam logic [7:0] X_INIT_V = 8'(X_INIT);
    localparam logic [6:0] Y_INIT_V = 7'(Y_INIT);
    localparam logic [8:0] X_MAX_W  = 9'(X_MAX);
    localparam logic [7:0] Y_MAX_W  = 8'(Y_MAX);
    localparam logic [8:0] STEP_X   = 9'(STEP);
    localparam logic [7:0] STEP_Y   = 8'(STEP);

    state_t     r_state;
    state_t     w_next;

    logic [7:0] r_box_x;
    logic [6:0] r_box_y;
    logic       r_dir_x;
    logic       r_dir_y;
    logic [7:0] r_bounce_cnt;
    logic       r_overrun;
    logic       r_req;
    logic       r_erase;

    logic [8:0] w_x_sum;
    logic       w_x_hit_hi;
    logic       w_x_hit_lo;
    logic       w_x_bounce;
    logic [7:0] w_x_new;
    logic [7:0] w_y_sum;
    logic       w_y_hit_hi;
    logic       w_y_hit_lo;
    logic       w_y_bounce;
    logic [6:0] w_y_new;
    logic [7:0] w_bounce_inc;

    // Next-state selection for the request/acknowledge sequence
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (go)   w_next = S_DRAW;
            S_DRAW:  if (done) w_next = S_WAIT;
            S_WAIT:  if (tick) w_next = S_ERASE;
            S_ERASE: if (done) w_next = S_MOVE;
            S_MOVE:            w_next = S_DRAW;
            default:           w_next = S_IDLE;
        endcase
    end

    // Axis update; widened by one bit so the limit compare never sees a wrap
    always_comb begin
        w_x_sum    = {1'b0, r_box_x} + STEP_X;
        w_x_hit_hi = (w_x_sum >= X_MAX_W);
        w_x_hit_lo = ({1'b0, r_box_x} <= STEP_X);
        w_x_bounce = r_dir_x ? w_x_hit_hi : w_x_hit_lo;
        if (r_dir_x)
            w_x_new = w_x_hit_hi ? X_MAX_W[7:0] : w_x_sum[7:0];
        else
            w_x_new = w_x_hit_lo ? '0 : (r_box_x - STEP_X[7:0]);

        w_y_sum    = {1'b0, r_box_y} + STEP_Y;
        w_y_hit_hi = (w_y_sum >= Y_MAX_W);
        w_y_hit_lo = ({1'b0, r_box_y} <= STEP_Y);
        w_y_bounce = r_dir_y ? w_y_hit_hi : w_y_hit_lo;
        if (r_dir_y)
            w_y_new = w_y_hit_hi ? Y_MAX_W[6:0] : w_y_sum[6:0];
        else
            w_y_new = w_y_hit_lo ? '0 : (r_box_y - STEP_Y[6:0]);

        w_bounce_inc = {6'd0, w_x_bounce & w_y_bounce, w_x_bounce ^ w_y_bounce};
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Registered outputs: request flags follow the state being entered,
    // position only moves in IDLE (reload) and MOVE (advance)
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_req        <= 1'b0;
            r_erase      <= 1'b0;
            r_box_x      <= X_INIT_V;
            r_box_y      <= Y_INIT_V;
            r_dir_x      <= 1'b1;
            r_dir_y      <= 1'b1;
            r_bounce_cnt <= '0;
            r_overrun    <= 1'b0;
        end else begin
            r_req   <= (w_next == S_DRAW) || (w_next == S_ERASE);
            r_erase <= (w_next == S_ERASE);
            if (r_state == S_IDLE) begin
                r_box_x <= X_INIT_V;
                r_box_y <= Y_INIT_V;
                r_dir_x <= 1'b1;
                r_dir_y <= 1'b1;
            end else if (r_state == S_MOVE) begin
                r_box_x      <= w_x_new;
                r_box_y      <= w_y_new;
                r_dir_x      <= r_dir_x ^ w_x_bounce;
                r_dir_y      <= r_dir_y ^ w_y_bounce;
                r_bounce_cnt <= r_bounce_cnt + w_bounce_inc;
            end
            if (tick && (r_state != S_WAIT) && (r_state != S_IDLE))
                r_overrun <= 1'b1;
        end
    end

    assign req        = r_req;
    assign erase      = r_erase;
    assign box_x      = r_box_x;
    assign box_y      = r_box_y;
    assign dir_x      = r_dir_x;
    assign dir_y      = r_dir_y;
    assign bounce_cnt = r_bounce_cnt;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_bounce_engine.sv
// Bench for bounce_engine: four instances with different geometry share one
// stimulus stream; a phase-level model predicts every output each cycle.
module tb_bounce_engine;

    localparam int N = 4;
    localparam int XI[N] = '{81, 155, 2, 155};
    localparam int YI[N] = '{0, 115, 5, 0};
    localparam int XM[N] = '{156, 156, 8, 156};
    localparam int YM[N] = '{116, 116, 20, 116};
    localparam int ST[N] = '{1, 1, 3, 1};

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic go    = 1'b0;
    logic tick  = 1'b0;
    logic done  = 1'b0;

    logic       rq  [N];
    logic       er  [N];
    logic [7:0] bx  [N];
    logic [6:0] by  [N];
    logic       dxo [N];
    logic       dyo [N];
    logic [7:0] bc  [N];
    logic       ov  [N];

    int n_checks = 0;
    int n_err    = 0;

    for (genvar g = 0; g < N; g++) begin : g_dut
        bounce_engine #(
            .X_INIT(XI[g]),
            .Y_INIT(YI[g]),
            .X_MAX (XM[g]),
            .Y_MAX (YM[g]),
            .STEP  (ST[g])
        ) u_dut (
            .clock     (clock),
            .reset     (reset),
            .go        (go),
            .tick      (tick),
            .done      (done),
            .req       (rq[g]),
            .erase     (er[g]),
            .box_x     (bx[g]),
            .box_y     (by[g]),
            .dir_x     (dxo[g]),
            .dir_y     (dyo[g]),
            .bounce_cnt(bc[g]),
            .overrun   (ov[g])
        );
    end

    initial forever #5 clock = ~clock;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 drawing, 2 waiting, 3 erasing, 4 moving
    int m_ph;
    int m_ov;
    int m_x[N], m_y[N], m_dx[N], m_dy[N], m_bc[N];
    bit m_valid = 1'b0;

    function automatic void axis(input int p, input int d, input int s, input int mx,
                                 output int np, output int nd, output int b);
        np = p; nd = d; b = 0;
        if (d == 1) begin
            if (p + s >= mx) begin np = mx; nd = 0; b = 1; end
            else np = p + s;
        end else begin
            if (p <= s) begin np = 0; nd = 1; b = 1; end
            else np = p - s;
        end
    endfunction

    always @(posedge clock or posedge reset) begin
        int nx, ndx, bxi, ny, ndy, byi;
        if (reset) begin
            m_ph    <= 0;
            m_ov    <= 0;
            m_valid <= 1'b1;
            for (int i = 0; i < N; i++) begin
                m_x[i] <= XI[i]; m_y[i] <= YI[i];
                m_dx[i] <= 1; m_dy[i] <= 1; m_bc[i] <= 0;
            end
        end else begin
            if (tick && m_ph != 2 && m_ph != 0) m_ov <= 1;
            case (m_ph)
                0: begin
                    for (int i = 0; i < N; i++) begin
                        m_x[i] <= XI[i]; m_y[i] <= YI[i];
                        m_dx[i] <= 1; m_dy[i] <= 1;
                    end
                    if (go) m_ph <= 1;
                end
                1: if (done) m_ph <= 2;
                2: if (tick) m_ph <= 3;
                3: if (done) m_ph <= 4;
                default: begin
                    for (int i = 0; i < N; i++) begin
                        axis(m_x[i], m_dx[i], ST[i], XM[i], nx, ndx, bxi);
                        axis(m_y[i], m_dy[i], ST[i], YM[i], ny, ndy, byi);
                        m_x[i]  <= nx;  m_dx[i] <= ndx;
                        m_y[i]  <= ny;  m_dy[i] <= ndy;
                        m_bc[i] <= (m_bc[i] + bxi + byi) % 256;
                    end
                    m_ph <= 1;
                end
            endcase
        end
    end

    // Compare every output of every instance against the model each cycle
    always @(negedge clock) begin
        if (m_valid) begin
            for (int i = 0; i < N; i++) begin
                chk($sformatf("u%0d.req", i),   int'(rq[i]),  int'(m_ph == 1 || m_ph == 3));
                chk($sformatf("u%0d.erase", i), int'(er[i]),  int'(m_ph == 3));
                chk($sformatf("u%0d.box_x", i), int'(bx[i]),  m_x[i]);
                chk($sformatf("u%0d.box_y", i), int'(by[i]),  m_y[i]);
                chk($sformatf("u%0d.dir_x", i), int'(dxo[i]), m_dx[i]);
                chk($sformatf("u%0d.dir_y", i), int'(dyo[i]), m_dy[i]);
                chk($sformatf("u%0d.bounce", i), int'(bc[i]), m_bc[i]);
                chk($sformatf("u%0d.overrun", i), int'(ov[i]), m_ov);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One full frame: tick, erase handshake, move, draw handshake
    task automatic frame(input int d1, input int d2, input bit tick_done);
        tick = 1'b1; done = tick_done; step(); tick = 1'b0; done = 1'b0;
        repeat (d1) step();
        done = 1'b1; step(); done = 1'b0;
        step();
        repeat (d2) step();
        done = 1'b1; step(); done = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("rst_req", int'(rq[0]), 0);
        chk("rst_x", int'(bx[0]), 81);
        chk("rst_y", int'(by[0]), 0);
        chk("rst_dirs", int'({dxo[0], dyo[0]}), 3);
        chk("rst_bounce", int'(bc[0]), 0);
        chk("rst_overrun", int'(ov[0]), 0);

        go = 1'b1; step(); go = 1'b0;
        chk("draw0_req", int'(rq[0]), 1);
        chk("draw0_erase", int'(er[0]), 0);
        chk("draw0_xy", int'({bx[0], 1'b0, by[0]}), {8'd81, 8'd0});
        done = 1'b1; step(); done = 1'b0;
        chk("draw0_req_fall", int'(rq[0]), 0);

        tick = 1'b1; step(); tick = 1'b0;
        chk("erase1_req", int'(rq[0]), 1);
        chk("erase1_erase", int'(er[0]), 1);
        chk("erase1_x", int'(bx[0]), 81);
        done = 1'b1; step(); done = 1'b0;
        chk("move1_req", int'(rq[0]), 0);
        step();
        chk("draw1_req", int'(rq[0]), 1);
        chk("draw1_erase", int'(er[0]), 0);
        chk("draw1_x", int'(bx[0]), 82);
        chk("draw1_y", int'(by[0]), 1);
        chk("edge_x", int'(bx[3]), 156);
        chk("edge_dirx", int'(dxo[3]), 0);
        chk("edge_bounce", int'(bc[3]), 1);
        chk("corner_xy", int'({bx[1], 1'b0, by[1]}), {8'd156, 8'd116});
        chk("corner_dirs", int'({dxo[1], dyo[1]}), 0);
        chk("corner_bounce", int'(bc[1]), 2);
        done = 1'b1; step(); done = 1'b0;

        frame(1, 0, 1'b0);
        chk("edge_back_x", int'(bx[3]), 155);
        chk("corner_back_x", int'(bx[1]), 155);
        chk("corner_back_y", int'(by[1]), 115);
        frame(0, 2, 1'b0);
        frame(2, 1, 1'b0);
        frame(0, 0, 1'b1);
        chk("clamp_x", int'(bx[2]), 0);
        chk("clamp_dirx", int'(dxo[2]), 1);
        chk("clamp_y", int'(by[2]), 20);
        chk("clamp_bounce", int'(bc[2]), 3);

        for (int f = 0; f < 500; f++) begin
            if ($urandom_range(0, 4) == 0) begin
                done = 1'b1; step(); done = 1'b0;
            end
            frame($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3) == 0);
        end

        chk("pre_overrun", int'(ov[0]), 0);
        tick = 1'b1; step(); tick = 1'b0;
        done = 1'b1; step(); done = 1'b0;
        step();
        tick = 1'b1; step(); tick = 1'b0;
        chk("overrun_set", int'(ov[0]), 1);
        chk("overrun_req", int'(rq[0]), 1);
        chk("overrun_pos", int'(bx[0]), m_x[0]);
        done = 1'b1; step(); done = 1'b0;

        tick = 1'b1; step(); tick = 1'b0;
        chk("mid_req", int'(rq[0]), 1);
        #3 reset = 1'b1;
        #1;
        chk("async_req", int'(rq[0]), 0);
        chk("async_erase", int'(er[0]), 0);
        chk("async_xy", int'({bx[0], 1'b0, by[0]}), {8'd81, 8'd0});
        chk("async_dirs", int'({dxo[0], dyo[0]}), 3);
        chk("async_bounce", int'(bc[0]), 0);
        chk("async_overrun", int'(ov[0]), 0);
        step();
        reset = 1'b0;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
